// File: rtl/nx_ram_1rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : nx_ram_1rw_arbiter
//  Purpose  : Shares one 1RW table RAM between two hardware requesters and
//             the software indirect-access path, with read-response routing.
//  Revision : 1.0  initial release
// ============================================================================
module nx_ram_1rw_arbiter #(
    parameter int N_DATA_BITS  = 32,
    parameter int N_ENTRIES    = 1024,
    parameter int RD_LATENCY   = 1,
    parameter int N_TIMER_BITS = 4,
    localparam int ADDR_BITS   = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hw0_vld,
    output logic                   hw0_rdy,
    input  logic                   hw0_we,
    input  logic [ADDR_BITS-1:0]   hw0_add,
    input  logic [N_DATA_BITS-1:0] hw0_bwe,
    input  logic [N_DATA_BITS-1:0] hw0_din,
    input  logic                   hw1_vld,
    output logic                   hw1_rdy,
    input  logic                   hw1_we,
    input  logic [ADDR_BITS-1:0]   hw1_add,
    input  logic [N_DATA_BITS-1:0] hw1_bwe,
    input  logic [N_DATA_BITS-1:0] hw1_din,
    input  logic                   sw_req,
    input  logic                   sw_we,
    input  logic [ADDR_BITS-1:0]   sw_add,
    input  logic [N_DATA_BITS-1:0] sw_wdat,
    output logic                   sw_ack,
    output logic                   hw_yield,
    output logic                   ram_cs,
    output logic                   ram_we,
    output logic [ADDR_BITS-1:0]   ram_add,
    output logic [N_DATA_BITS-1:0] ram_bwe,
    output logic [N_DATA_BITS-1:0] ram_din,
    input  logic [N_DATA_BITS-1:0] ram_dout,
    output logic                   rsp0_vld,
    output logic                   rsp1_vld,
    output logic                   sw_rsp_vld,
    output logic [N_DATA_BITS-1:0] rsp_dat
);

    localparam logic [N_TIMER_BITS-1:0] c_tmax   = '1;
    localparam logic [1:0]              c_id_hw0 = 2'd0;
    localparam logic [1:0]              c_id_hw1 = 2'd1;
    localparam logic [1:0]              c_id_sw  = 2'd2;

    logic [N_TIMER_BITS-1:0] r_timer;
    logic                    r_last;      // 1: hw1 was granted last, so hw0 wins the next tie
    logic                    r_pipe_vld [RD_LATENCY];
    logic [1:0]              r_pipe_id  [RD_LATENCY];

    logic                   w_force;
    logic                   w_gnt_hw0;
    logic                   w_gnt_hw1;
    logic                   w_gnt_sw;
    logic                   w_ram_cs;
    logic                   w_ram_we;
    logic [ADDR_BITS-1:0]   w_ram_add;
    logic [N_DATA_BITS-1:0] w_ram_bwe;
    logic [N_DATA_BITS-1:0] w_ram_din;
    logic [1:0]             w_ram_id;
    logic                   w_issue_rd;
    logic                   w_tail_vld;
    logic [1:0]             w_tail_id;

    always_comb begin
        w_force   = sw_req && (r_timer == c_tmax);
        w_gnt_hw0 = 1'b0;
        w_gnt_hw1 = 1'b0;
        w_gnt_sw  = 1'b0;
        if (!rst) begin
            if (w_force) begin
                w_gnt_sw = 1'b1;
            end else if (hw0_vld && hw1_vld) begin
                w_gnt_hw0 = r_last;
                w_gnt_hw1 = !r_last;
            end else if (hw0_vld) begin
                w_gnt_hw0 = 1'b1;
            end else if (hw1_vld) begin
                w_gnt_hw1 = 1'b1;
            end else if (sw_req) begin
                w_gnt_sw = 1'b1;
            end
        end
    end

    always_comb begin
        w_ram_cs  = 1'b0;
        w_ram_we  = 1'b0;
        w_ram_add = '0;
        w_ram_bwe = '0;
        w_ram_din = '0;
        w_ram_id  = c_id_hw0;
        if (w_gnt_hw0) begin
            w_ram_cs  = 1'b1;
            w_ram_we  = hw0_we;
            w_ram_add = hw0_add;
            w_ram_bwe = hw0_bwe;
            w_ram_din = hw0_din;
            w_ram_id  = c_id_hw0;
        end else if (w_gnt_hw1) begin
            w_ram_cs  = 1'b1;
            w_ram_we  = hw1_we;
            w_ram_add = hw1_add;
            w_ram_bwe = hw1_bwe;
            w_ram_din = hw1_din;
            w_ram_id  = c_id_hw1;
        end else if (w_gnt_sw) begin
            w_ram_cs  = 1'b1;
            w_ram_we  = sw_we;
            w_ram_add = sw_add;
            w_ram_bwe = '1;
            w_ram_din = sw_wdat;
            w_ram_id  = c_id_sw;
        end
        w_issue_rd = w_ram_cs && !w_ram_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (sw_req && !w_gnt_sw) begin
            r_timer <= (r_timer == c_tmax) ? r_timer : r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    // A forced software grant carries no hw grant, so the pointer holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_gnt_hw0) begin
            r_last <= 1'b0;
        end else if (w_gnt_hw1) begin
            r_last <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_id[i]  <= 2'd0;
            end
        end else begin
            r_pipe_vld[0] <= w_issue_rd;
            r_pipe_id[0]  <= w_ram_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    assign w_tail_vld = r_pipe_vld[RD_LATENCY-1] && !rst;
    assign w_tail_id  = r_pipe_id[RD_LATENCY-1];

    assign hw0_rdy    = w_gnt_hw0;
    assign hw1_rdy    = w_gnt_hw1;
    assign sw_ack     = w_gnt_sw;
    assign hw_yield   = w_force && !rst;
    assign ram_cs     = w_ram_cs;
    assign ram_we     = w_ram_we;
    assign ram_add    = w_ram_add;
    assign ram_bwe    = w_ram_bwe;
    assign ram_din    = w_ram_din;
    assign rsp0_vld   = w_tail_vld && (w_tail_id == c_id_hw0);
    assign rsp1_vld   = w_tail_vld && (w_tail_id == c_id_hw1);
    assign sw_rsp_vld = w_tail_vld && (w_tail_id == c_id_sw);
    assign rsp_dat    = w_tail_vld ? ram_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_nx_ram_1rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nx_ram_1rw_arbiter
//  Purpose  : Self-checking bench for nx_ram_1rw_arbiter with a RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nx_ram_1rw_arbiter;

    localparam int DW   = 32;
    localparam int NE   = 16;
    localparam int AW   = 4;
    localparam int RDL  = 2;
    localparam int TB   = 2;
    localparam int TMAX = 3;

    typedef struct { int due; int id; logic [DW-1:0] dat; } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hw0_vld, hw0_rdy, hw0_we, hw1_vld, hw1_rdy, hw1_we;
    logic [AW-1:0] hw0_add, hw1_add, sw_add, ram_add;
    logic [DW-1:0] hw0_bwe, hw0_din, hw1_bwe, hw1_din, sw_wdat;
    logic          sw_req, sw_we, sw_ack, hw_yield, ram_cs, ram_we;
    logic [DW-1:0] ram_bwe, ram_din, ram_dout, rsp_dat;
    logic          rsp0_vld, rsp1_vld, sw_rsp_vld;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic          mem_load = 1'b1;
    logic [DW-1:0] ram_mem [NE];
    logic [DW-1:0] rd_dly  [RDL];
    logic [DW-1:0] ref_mem [NE];
    rsp_t          exp_q[$];

    nx_ram_1rw_arbiter #(
        .N_DATA_BITS(DW), .N_ENTRIES(NE), .RD_LATENCY(RDL), .N_TIMER_BITS(TB)
    ) dut (
        .clk(clk), .rst(rst),
        .hw0_vld(hw0_vld), .hw0_rdy(hw0_rdy), .hw0_we(hw0_we), .hw0_add(hw0_add),
        .hw0_bwe(hw0_bwe), .hw0_din(hw0_din),
        .hw1_vld(hw1_vld), .hw1_rdy(hw1_rdy), .hw1_we(hw1_we), .hw1_add(hw1_add),
        .hw1_bwe(hw1_bwe), .hw1_din(hw1_din),
        .sw_req(sw_req), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat),
        .sw_ack(sw_ack), .hw_yield(hw_yield),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_add(ram_add), .ram_bwe(ram_bwe),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld), .sw_rsp_vld(sw_rsp_vld),
        .rsp_dat(rsp_dat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(int i);
        return 32'hC0DE0000 | (i * 32'h00000111);
    endfunction

    // RAM macro stand-in with RDL cycles of read latency
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < NE; i++) ram_mem[i] <= init_val(i);
        end else if (ram_cs && ram_we) begin
            ram_mem[ram_add] <= (ram_mem[ram_add] & ~ram_bwe) | (ram_din & ram_bwe);
        end
        rd_dly[0] <= (ram_cs && !ram_we) ? ram_mem[ram_add] : '0;
        for (int i = 1; i < RDL; i++) rd_dly[i] <= rd_dly[i-1];
    end
    assign ram_dout = rd_dly[RDL-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        hw0_vld = 0; hw0_we = 0; hw0_add = '0; hw0_bwe = '0; hw0_din = '0;
        hw1_vld = 0; hw1_we = 0; hw1_add = '0; hw1_bwe = '0; hw1_din = '0;
        sw_req  = 0; sw_we  = 0; sw_add  = '0; sw_wdat = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain;
        idle_inputs();
        for (int i = 0; i < RDL + 1; i++) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        hw0_vld = 1; hw1_vld = 1; sw_req = 1; hw0_add = 4'd3; hw1_add = 4'd7;
        @(negedge clk);
        checks++;
        if ({hw0_rdy, hw1_rdy, sw_ack, hw_yield, ram_cs, rsp0_vld, rsp1_vld, sw_rsp_vld} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {hw0_rdy, hw1_rdy, sw_ack, hw_yield, ram_cs, rsp0_vld, rsp1_vld, sw_rsp_vld});
        end
        checks++;
        if (rsp_dat !== '0) begin
            failures++;
            $display("FAIL reset_rsp_dat: got %h expected 0", rsp_dat);
        end
        tick();
        rst = 1'b0; sw_req = 0;
        @(negedge clk);
        checks++;
        if ({hw0_rdy, hw1_rdy, ram_add} !== {2'b10, 4'd3}) begin
            failures++;
            $display("FAIL reset_first_contention: got %b/%0d expected 10/3", {hw0_rdy, hw1_rdy}, ram_add);
        end
        tick();
        drain();
    endtask

    task automatic test_round_robin;
        logic [2+DW:0] e, a;
        do_reset();
        hw0_vld = 1; hw0_add = 4'd3; hw1_vld = 1; hw1_add = 4'd7;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({hw0_rdy, hw1_rdy} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", i, {hw0_rdy, hw1_rdy},
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (i < RDL) e = '0;
            else if ((i - RDL) % 2 == 0) e = {3'b100, ref_mem[3]};
            else e = {3'b010, ref_mem[7]};
            a = {rsp0_vld, rsp1_vld, sw_rsp_vld, rsp_dat};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL rr_rsp[%0d]: got %h expected %h", i, a, e);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_starvation;
        logic ea;
        do_reset();
        hw0_vld = 1; hw0_add = 4'd3; hw1_vld = 1; hw1_add = 4'd7;
        sw_we = 0; sw_add = 4'd2;
        for (int i = 0; i < 17; i++) begin
            sw_req = (i >= 10 && i <= 13);
            @(negedge clk);
            ea = (i == 10 + TMAX);
            checks++;
            if ({sw_ack, hw_yield, hw0_rdy | hw1_rdy} !== {ea, ea, !ea}) begin
                failures++;
                $display("FAIL starve_grant[%0d]: got %b expected %b", i,
                         {sw_ack, hw_yield, hw0_rdy | hw1_rdy}, {ea, ea, !ea});
            end
            if (i == 14) begin
                checks++;
                if (dut.r_timer !== '0) begin
                    failures++;
                    $display("FAIL starve_timer_clear: got %0d expected 0", dut.r_timer);
                end
            end
            if (i == 10 + TMAX + RDL) begin
                checks++;
                if ({sw_rsp_vld, rsp_dat} !== {1'b1, ref_mem[2]}) begin
                    failures++;
                    $display("FAIL starve_sw_rsp: got %b/%h expected 1/%h", sw_rsp_vld, rsp_dat, ref_mem[2]);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_sw_write_idle;
        do_reset();
        sw_req = 1; sw_we = 1; sw_add = 4'd5; sw_wdat = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if ({sw_ack, ram_cs, ram_we, hw_yield} !== 4'b1110) begin
            failures++;
            $display("FAIL sw_write_ctrl: got %b expected 1110", {sw_ack, ram_cs, ram_we, hw_yield});
        end
        checks++;
        if ({ram_add, ram_bwe, ram_din} !== {4'd5, 32'hFFFFFFFF, 32'hA5A5A5A5}) begin
            failures++;
            $display("FAIL sw_write_data: got %h/%h/%h expected 5/ffffffff/a5a5a5a5", ram_add, ram_bwe, ram_din);
        end
        ref_mem[5] = 32'hA5A5A5A5;
        tick();
        sw_req = 0;
        for (int k = 0; k < RDL + 1; k++) begin
            @(negedge clk);
            checks++;
            if ({rsp0_vld, rsp1_vld, sw_rsp_vld} !== 3'b000) begin
                failures++;
                $display("FAIL sw_write_no_rsp[%0d]: got %b expected 000", k, {rsp0_vld, rsp1_vld, sw_rsp_vld});
            end
            tick();
        end
    endtask

    task automatic test_masked_write;
        logic [DW-1:0] merged;
        do_reset();
        hw1_vld = 1; hw1_we = 1; hw1_add = 4'd9; hw1_bwe = 32'h0000FFFF; hw1_din = 32'h12345678;
        @(negedge clk);
        checks++;
        if ({hw1_rdy, ram_we, ram_add, ram_bwe, ram_din} !== {2'b11, 4'd9, 32'h0000FFFF, 32'h12345678}) begin
            failures++;
            $display("FAIL masked_write_port: got %b%b/%h/%h/%h expected 11/9/0000ffff/12345678",
                     hw1_rdy, ram_we, ram_add, ram_bwe, ram_din);
        end
        merged = (ref_mem[9] & 32'hFFFF0000) | 32'h00005678;
        ref_mem[9] = merged;
        tick();
        hw1_vld = 0; hw0_vld = 1; hw0_we = 0; hw0_add = 4'd9;
        @(negedge clk);
        checks++;
        if (hw0_rdy !== 1'b1) begin
            failures++;
            $display("FAIL masked_read_grant: got %b expected 1", hw0_rdy);
        end
        tick();
        hw0_vld = 0;
        for (int k = 1; k < RDL; k++) tick();
        @(negedge clk);
        checks++;
        if ({rsp0_vld, rsp1_vld, sw_rsp_vld, rsp_dat} !== {3'b100, merged}) begin
            failures++;
            $display("FAIL masked_read_rsp: got %b/%h expected 100/%h",
                     {rsp0_vld, rsp1_vld, sw_rsp_vld}, rsp_dat, merged);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_inflight;
        do_reset();
        hw0_vld = 1; hw0_add = 4'd3;
        @(negedge clk);
        checks++;
        if (hw0_rdy !== 1'b1) begin
            failures++;
            $display("FAIL inflight_grant: got %b expected 1", hw0_rdy);
        end
        tick();
        hw0_vld = 0; rst = 1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) rst = 0;
            if (k == 2) begin hw0_vld = 1; hw1_vld = 1; hw1_add = 4'd7; end
            @(negedge clk);
            checks++;
            if ({rsp0_vld, rsp1_vld, sw_rsp_vld} !== 3'b000) begin
                failures++;
                $display("FAIL inflight_no_rsp[%0d]: got %b expected 000", k, {rsp0_vld, rsp1_vld, sw_rsp_vld});
            end
            if (k == 2) begin
                checks++;
                if ({hw0_rdy, hw1_rdy} !== 2'b10) begin
                    failures++;
                    $display("FAIL inflight_first_contention: got %b expected 10", {hw0_rdy, hw1_rdy});
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_sw_drop;
        int exp_g [9] = '{0, 1, 0, 1, 0, 1, 0, 2, 1};
        do_reset();
        hw0_vld = 1; hw0_add = 4'd3; hw1_vld = 1; hw1_add = 4'd7;
        sw_we = 0; sw_add = 4'd4;
        for (int i = 0; i < 9; i++) begin
            sw_req = (i == 1 || i == 2 || (i >= 4 && i <= 7));
            @(negedge clk);
            checks++;
            if ({hw0_rdy, hw1_rdy, sw_ack} !== {exp_g[i] == 0, exp_g[i] == 1, exp_g[i] == 2}) begin
                failures++;
                $display("FAIL sw_drop_grant[%0d]: got %b expected %b", i, {hw0_rdy, hw1_rdy, sw_ack},
                         {exp_g[i] == 0, exp_g[i] == 1, exp_g[i] == 2});
            end
            if (i == 4) begin
                checks++;
                if (dut.r_timer !== '0) begin
                    failures++;
                    $display("FAIL sw_drop_timer: got %0d expected 0", dut.r_timer);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_random;
        int            m_last, m_wait, win;
        logic          force_c, e_we;
        logic [AW-1:0] e_add;
        logic [DW-1:0] e_bwe, e_din;
        logic [2+DW:0] e_rsp, a_rsp;
        logic [1+AW+2*DW-1:0] e_port;
        do_reset();
        m_last = 1; m_wait = 0; exp_q.delete();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            force_c = sw_req && (m_wait >= TMAX);
            if (force_c) win = 2;
            else if (hw0_vld && hw1_vld) win = (m_last == 1) ? 0 : 1;
            else if (hw0_vld) win = 0;
            else if (hw1_vld) win = 1;
            else if (sw_req) win = 2;
            else win = -1;
            e_we = 0; e_add = '0; e_bwe = '0; e_din = '0;
            if (win == 0) begin e_we = hw0_we; e_add = hw0_add; e_bwe = hw0_bwe; e_din = hw0_din; end
            if (win == 1) begin e_we = hw1_we; e_add = hw1_add; e_bwe = hw1_bwe; e_din = hw1_din; end
            if (win == 2) begin e_we = sw_we; e_add = sw_add; e_bwe = '1; e_din = sw_wdat; end
            checks++;
            if ({hw0_rdy, hw1_rdy, sw_ack, hw_yield, ram_cs} !== {win == 0, win == 1, win == 2, force_c, win >= 0}) begin
                failures++;
                $display("FAIL rand_grant[%0d]: got %b expected %b", n, {hw0_rdy, hw1_rdy, sw_ack, hw_yield, ram_cs},
                         {win == 0, win == 1, win == 2, force_c, win >= 0});
            end
            e_port = {e_we, e_add, e_bwe, e_din};
            checks++;
            if ({ram_we, ram_add, ram_bwe, ram_din} !== e_port) begin
                failures++;
                $display("FAIL rand_ram_port[%0d]: got %h expected %h", n, {ram_we, ram_add, ram_bwe, ram_din}, e_port);
            end
            e_rsp = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e_rsp = {exp_q[0].id == 0, exp_q[0].id == 1, exp_q[0].id == 2, exp_q[0].dat};
                void'(exp_q.pop_front());
            end
            a_rsp = {rsp0_vld, rsp1_vld, sw_rsp_vld, rsp_dat};
            checks++;
            if (a_rsp !== e_rsp) begin
                failures++;
                $display("FAIL rand_rsp[%0d]: got %h expected %h", n, a_rsp, e_rsp);
            end
            if (win >= 0 && !e_we) exp_q.push_back('{cyc + RDL, win, ref_mem[e_add]});
            if (win >= 0 && e_we) ref_mem[e_add] = (ref_mem[e_add] & ~e_bwe) | (e_din & e_bwe);
            if (win == 0 || win == 1) m_last = win;
            m_wait = (sw_req && win != 2) ? m_wait + 1 : 0;
            tick();
            if (!hw0_vld || win == 0) begin
                hw0_vld = ($urandom % 4) != 0; hw0_we = 1'($urandom % 2); hw0_add = AW'($urandom % NE);
                hw0_bwe = $urandom; hw0_din = $urandom;
            end
            if (!hw1_vld || win == 1) begin
                hw1_vld = ($urandom % 4) != 0; hw1_we = 1'($urandom % 2); hw1_add = AW'($urandom % NE);
                hw1_bwe = $urandom; hw1_din = $urandom;
            end
            if (sw_req && win != 2) begin
                if ($urandom % 16 == 0) sw_req = 0;
            end else begin
                sw_req = ($urandom % 5) == 0; sw_we = 1'($urandom % 2); sw_add = AW'($urandom % NE);
                sw_wdat = $urandom;
            end
        end
        checks++;
        if (exp_q.size() > RDL) begin
            failures++;
            $display("FAIL rand_rsp_backlog: got %0d pending expected <= %0d", exp_q.size(), RDL);
        end
        drain();
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < NE; i++) ref_mem[i] = init_val(i);
        tick();
        mem_load = 1'b0;
        tick();
        test_reset();
        test_round_robin();
        test_starvation();
        test_sw_write_idle();
        test_masked_write();
        test_reset_inflight();
        test_sw_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nx_ram_1rw_arbiter.md
# nx_ram_1rw_arbiter

Arbiter and sequencer for a single-port (1RW) table RAM shared by two hardware requesters and the software indirect-access path. Each cycle it picks at most one access and drives the RAM port. It tracks read latency so every read response returns to its originator. A starvation timer guarantees software forward progress under continuous hardware load. The block sits between the engine datapath, the indirect-access controller and the RAM macro wrapper.

## Interface
Parameters:
- N_DATA_BITS, 32, RAM word width.
- N_ENTRIES, 1024, RAM depth; address width is clog2(N_ENTRIES), min 1.
- RD_LATENCY, 1, cycles from RAM cs (read) to valid ram_dout; legal range 1..8.
- N_TIMER_BITS, 4, software starvation timer width; TMAX = 2^N_TIMER_BITS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- hw0_vld / hw1_vld  in  1  hardware request valid; hold until accepted.
- hw0_rdy / hw1_rdy  out  1  grant; the request is accepted when vld&&rdy.
- hw0_we / hw1_we  in  1  1=write, 0=read.
- hw0_add / hw1_add  in  clog2(N_ENTRIES)  address.
- hw0_bwe / hw1_bwe  in  N_DATA_BITS  bit write enables.
- hw0_din / hw1_din  in  N_DATA_BITS  write data.
- sw_req  in  1  software request; hold stable until sw_ack.
- sw_we, sw_add, sw_wdat  in  1 / clog2(N_ENTRIES) / N_DATA_BITS  software command.
- sw_ack  out  1  one-cycle pulse; the software access is issued this cycle.
- hw_yield  out  1  software is being forced ahead of hardware this cycle.
- ram_cs, ram_we  out  1  RAM port controls.
- ram_add  out  clog2(N_ENTRIES)  RAM address.
- ram_bwe, ram_din  out  N_DATA_BITS  RAM write enables and write data.
- ram_dout  in  N_DATA_BITS  RAM read data.
- rsp0_vld / rsp1_vld / sw_rsp_vld  out  1  read response strobe per originator.
- rsp_dat  out  N_DATA_BITS  read data, common to all originators.

## Operation
- Candidates each cycle: hw0, hw1, sw. At most one grant per cycle.
- Normal priority: hardware over software.
  - hw0 vs hw1: round-robin via pointer `last`. When both are valid, grant the one not equal to `last`.
  - `last` updates to the granted id on every hardware grant.
  - A single valid hw requester is granted immediately.
- Software is granted when no hw is valid, or when timer == TMAX (forced grant).
- In a forced cycle: sw_ack=1, hw_yield=1, both hw_rdy=0.
- Starvation timer:
  - Increments each cycle with sw_req && !sw_ack, saturating at TMAX.
  - Clears to 0 on sw_ack or when sw_req=0.
- RAM drive (combinational from the winner):
  - ram_cs=1 on any grant.
  - ram_we, ram_add, ram_din taken from the winner.
  - ram_bwe = winner's bwe for hw, all-ones for sw.
  - With no grant: ram_cs=0, ram_we=0, other RAM outputs 0.
- Response tracking: shift register of RD_LATENCY stages, each {vld, id[1:0]} (0=hw0, 1=hw1, 2=sw).
  - Loaded on granted reads only; writes produce no response.
  - The tail stage drives the rspN_vld strobe and rsp_dat=ram_dout.
  - rsp_dat=0 when no response is valid.
- Back-to-back reads from mixed originators are supported every cycle; responses return in issue order.

## Timing
- Grant is combinational: rdy/ack and the RAM strobes appear in the same cycle as vld/req.
- A read accepted in cycle T produces its response strobe in cycle T+RD_LATENCY, for exactly one cycle.
- Worst-case software wait under continuous hw load: sw_ack in cycle S+TMAX, where S is the first cycle of sw_req.
- Reset (rst=1, sampled at posedge):
  - Next state: timer=0, last=1 (hw0 wins first contention), response pipe cleared.
  - While rst=1: all rdy/ack, ram_cs, response strobes and hw_yield are forced to 0.
- Reset mid-operation discards in-flight read responses; no strobe is emitted for them after reset.
- sw_req dropped before ack: legal; the timer clears and no access is issued.
- A simultaneous forced software grant and hw requests leaves `last` unchanged.

## Test plan
- hw0 and hw1 both reading continuously from reset, RD_LATENCY=2 -> grants alternate hw0,hw1,hw0,... starting with hw0; each rspN_vld fires 2 cycles after its grant with the matching ram_dout.
- N_TIMER_BITS=2, both hw saturating, sw_req read asserted at cycle 10 -> sw_ack and hw_yield at cycle 13, both hw_rdy=0 at cycle 13, sw_rsp_vld at cycle 13+RD_LATENCY, timer back to 0 at cycle 14.
- Idle hw, sw write of 0xA5A5A5A5 to address 5 -> same-cycle sw_ack, ram_cs=1, ram_we=1, ram_bwe=all-ones; no response strobe.
- hw1 write with bwe=0x0000FFFF followed by an hw0 read of the same address -> RAM sees the masked write, and rsp0_vld returns the merged data.
- rst asserted 1 cycle after a read grant with RD_LATENCY=3 -> no rsp strobe follows; after release, the first contention grants hw0.
- sw_req asserted for 2 cycles under hw load, then dropped (N_TIMER_BITS=4) -> no sw_ack, timer returns to 0, hw round-robin undisturbed.
